// File: rtl/sound_sequencer.sv
// Melody sequencer: walks a synchronous ROM of {key, duration} words, timing notes and gaps on tick.
// Optional KEY_PREEMPT_EN: a held live key overrides note_code and pauses the melody count.
module sound_sequencer #(
    parameter int ADDR_W    = 8,
    parameter int GAP_TICKS = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              stop,
    input  logic [ADDR_W-1:0] song_base,
    input  logic              tick,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [15:0]       rom_data,
    input  logic              key_valid,
    input  logic [7:0]        key_code,
    output logic [7:0]        note_code,
    output logic              busy,
    output logic              done
);
    typedef enum logic [2:0] {IDLE, FETCH, LOAD, PLAY, GAP} state_t;

    localparam logic [7:0] GAP_CNT = 8'(GAP_TICKS);

    state_t            state_q;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] addr_inc_d;
    logic [7:0]        cnt_q;
    logic [7:0]        note_q;
    logic              done_q;
    logic              tick_d;
    logic [7:0]        dur_d;

    assign dur_d      = rom_data[7:0];
    assign addr_inc_d = addr_q + 1'b1;

`ifdef KEY_PREEMPT_EN
    logic       kv_q;
    logic [7:0] kc_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            kv_q <= 1'b0;
            kc_q <= '0;
        end else begin
            kv_q <= key_valid;
            kc_q <= key_code;
        end
    end

    // Melody keeps its own note in note_q so it can be restored when the key drops.
    assign tick_d    = tick & ~key_valid;
    assign note_code = kv_q ? kc_q : note_q;
`else
    logic unused_keys;
    assign unused_keys = ^{key_valid, key_code};
    assign tick_d      = tick;
    assign note_code   = note_q;
`endif

    assign rom_addr = addr_q;
    assign busy     = (state_q != IDLE);
    assign done     = done_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            cnt_q   <= '0;
            note_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (stop) begin
                state_q <= IDLE;
                note_q  <= '0;
                cnt_q   <= '0;
            end else if (start) begin
                state_q <= FETCH;
                addr_q  <= song_base;
                note_q  <= '0;
                cnt_q   <= '0;
            end else begin
                case (state_q)
                    FETCH: state_q <= LOAD;
                    LOAD: begin
                        if (dur_d == 8'd0) begin
                            note_q  <= '0;
                            done_q  <= 1'b1;
                            state_q <= IDLE;
                        end else begin
                            note_q  <= rom_data[15:8];
                            cnt_q   <= dur_d;
                            state_q <= PLAY;
                        end
                    end
                    PLAY: begin
                        if (tick_d) begin
                            if (cnt_q == 8'd1) begin
                                if (GAP_TICKS > 0) begin
                                    note_q  <= '0;
                                    cnt_q   <= GAP_CNT;
                                    state_q <= GAP;
                                end else begin
                                    // Legato: the note keeps sounding through FETCH/LOAD.
                                    cnt_q   <= '0;
                                    addr_q  <= addr_inc_d;
                                    state_q <= FETCH;
                                end
                            end else begin
                                cnt_q <= cnt_q - 8'd1;
                            end
                        end
                    end
                    GAP: begin
                        if (tick_d) begin
                            if (cnt_q == 8'd1) begin
                                cnt_q   <= '0;
                                addr_q  <= addr_inc_d;
                                state_q <= FETCH;
                            end else begin
                                cnt_q <= cnt_q - 8'd1;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule
